score_text_writer: RTL and testbench
====================================

SCORE_TEXT_WRITER -- requirements
Module: score_text_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 11'd0, meaning the character-buffer address of the most significant digit.
REQ-002 SHALL have parameter N_DIGITS, default 6, meaning the number of decimal digits written; it is fixed at 6 and other values are unsupported.
REQ-003 SHALL have port Clk, input, 1, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to convert and write score.
REQ-006 SHALL have port score, input, 20, an unsigned binary score, sampled only on the accepted start cycle.
REQ-007 SHALL have port busy, output, 1, high from the cycle after acceptance until done is asserted.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the last character has been written.
REQ-009 SHALL have port wr_en, output, 1, the character-buffer write strobe.
REQ-010 SHALL have port wr_addr, output, 11, the character-buffer write address.
REQ-011 SHALL have port wr_data, output, 8, the character code written (ASCII, font ROM code space).

Function
REQ-012 SHALL implement the states IDLE, CONVERT, WRITE and DONE, and SHALL be in IDLE after reset.
REQ-013 In IDLE, start=1 SHALL latch score, clear the 24-bit BCD register and the counter, and enter CONVERT on the next edge; start in any other state SHALL be ignored.
REQ-014 If the latched score is greater than 999999, it SHALL be replaced by 999999 (saturation) before conversion.
REQ-015 CONVERT SHALL last exactly 20 cycles, one double-dabble iteration per cycle: add 3 to each BCD nibble that is 5 or more, then shift {bcd, bin} left by 1.
REQ-016 After the 20th CONVERT cycle, the block SHALL enter WRITE with digit index i=0.
REQ-017 WRITE SHALL last exactly 6 cycles.
REQ-018 In each WRITE cycle, wr_en SHALL be 1, wr_addr SHALL equal BASE_ADDR+i, and wr_data SHALL equal 8'h30+digit, where i=0 is the most significant digit.
REQ-019 wr_addr SHALL wrap modulo 2^11.
REQ-020 After the 6th write, the block SHALL enter DONE for exactly 1 cycle with done=1 and wr_en=0, then return to IDLE.
REQ-021 busy SHALL be 1 in CONVERT and WRITE, and 0 in IDLE and DONE.
REQ-022 Start-to-done latency SHALL be 27 cycles, with done high on the 27th rising edge after the edge that sampled start.
REQ-023 start asserted during DONE SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted, so back-to-back operations are possible.
REQ-024 wr_en SHALL be 0 and wr_data SHALL be 8'h00 outside WRITE; wr_addr is don't-care outside WRITE.

Reset
REQ-025 Reset_n=0 SHALL immediately force the state to IDLE, and busy, done, wr_en, wr_addr, wr_data, the counters and the BCD register to 0, without waiting for a clock edge.
REQ-026 Reset asserted mid-CONVERT or mid-WRITE SHALL abort the operation with no further writes; after Reset_n is released, the first start SHALL begin a fresh conversion.

Configuration
REQ-027 The leading-zero blanking feature SHALL be controlled by macro SCORE_LEADING_ZERO_BLANK_EN.
REQ-028 With SCORE_LEADING_ZERO_BLANK_EN defined, every zero digit before the first nonzero digit SHALL be written as 8'h20 (space), and digit i=5 SHALL always be written as a digit.
REQ-029 Without SCORE_LEADING_ZERO_BLANK_EN, all 6 digits SHALL be written as 8'h30-8'h39.
REQ-030 Timing and the number of writes SHALL be identical with and without SCORE_LEADING_ZERO_BLANK_EN.

Verification
REQ-031 With score=12345 and BASE_ADDR=40: writes SHALL be addresses 40..45 with data 30,31,32,33,34,35 (hex) without the macro, or 20,31,32,33,34,35 with the macro; done SHALL pulse 27 cycles after start.
REQ-032 With score=0: without the macro, six writes of 8'h30; with the macro, 20,20,20,20,20,30.
REQ-033 With score=20'hFFFFF (1048575): the block SHALL write 39 six times (saturation).
REQ-034 A second start at CONVERT cycle 5 SHALL be ignored: exactly 6 writes occur, containing the first score.
REQ-035 Reset_n pulsed low during the 3rd WRITE cycle SHALL cause wr_en, busy and done to go to 0 asynchronously, with no further writes; a following start with score=7 SHALL produce 30,30,30,30,30,37 with no macro.
REQ-036 With BASE_ADDR=11'h7FE and score=999999, wr_addr SHALL be 7FE, 7FF, 000, 001, 002, 003, with 39 written at each.

Source files
------------

// File: rtl/score_text_writer.sv
// Converts a 20-bit binary score to six decimal characters (double dabble) and
// writes them to a character buffer. Optional feature macro: SCORE_LEADING_ZERO_BLANK_EN.
module score_text_writer #(
  parameter logic [10:0] BASE_ADDR = 11'd0,
  parameter int          N_DIGITS  = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [19:0] score,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data
);

  // Handshake: start is honoured only while in IDLE (busy=0, done=0) and score is
  // sampled on that same edge; busy stays high through CONVERT and WRITE, and done
  // pulses for one cycle afterwards. Starts seen while busy or done are dropped.

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  localparam logic [19:0] SCORE_MAX  = 20'd999999;
  localparam logic [4:0]  LAST_ITER  = 5'd19;
  localparam logic [2:0]  LAST_DIGIT = 3'(N_DIGITS - 1);

  state_t      state;
  state_t      state_next;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [4:0]  cnt;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic [7:0]  char_code;

  // The most significant remaining digit always sits in the top nibble.
  assign digit = bcd[23:20];

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic seen_nz;

  always_comb begin
    char_code = {4'h3, digit};
    if (!seen_nz && (digit == 4'd0) && (idx != LAST_DIGIT)) char_code = 8'h20;
  end
`else
  assign char_code = {4'h3, digit};
`endif

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 6; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 11'd0;
    wr_data    = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_next = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_next = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = BASE_ADDR + {8'd0, idx};
        wr_data = char_code;
        if (idx == LAST_DIGIT) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin <= 20'd0;
      bcd <= 24'd0;
      cnt <= 5'd0;
      idx <= 3'd0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      seen_nz <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin <= (score > SCORE_MAX) ? SCORE_MAX : score;
            bcd <= 24'd0;
            cnt <= 5'd0;
            idx <= 3'd0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            seen_nz <= 1'b0;
`endif
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 5'd1;
        end
        WRITE: begin
          bcd <= bcd << 4;
          idx <= idx + 3'd1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
          seen_nz <= seen_nz | (digit != 4'd0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_writer.sv
// Bench for score_text_writer: two instances (BASE_ADDR 40 and 11'h7FE) share
// stimulus and are checked every cycle against a cycle-count/arithmetic model.
module tb_score_text_writer;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [19:0] score;
  logic        busy_a, done_a, wr_en_a, busy_b, done_b, wr_en_b;
  logic [10:0] wr_addr_a, wr_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;

  localparam logic [10:0] BASE_A = 11'd40;
  localparam logic [10:0] BASE_B = 11'h7FE;

  score_text_writer #(.BASE_ADDR(BASE_A), .N_DIGITS(6)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .score(score),
    .busy(busy_a), .done(done_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  score_text_writer #(.BASE_ADDR(BASE_B), .N_DIGITS(6)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .score(score),
    .busy(busy_b), .done(done_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Character i (0 = most significant) of the saturated decimal value.
  function automatic logic [7:0] exp_char(input int unsigned v, input int i);
    int unsigned s;
    int unsigned pw;
    int unsigned d;
    s  = (v > 999999) ? 999999 : v;
    pw = 1;
    for (int k = 0; k < 5 - i; k++) pw = pw * 10;
    d = (s / pw) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (i < 5 && (s / pw) == 0) return 8'h20;
`endif
    return 8'h30 + 8'(d);
  endfunction

  // age: 0 = idle; 1..20 converting; 21..26 writing digit age-21; 27 done.
  int         age = 0;
  logic [7:0] exp_q[$];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      age = 0;
      exp_q.delete();
    end else if (age == 0) begin
      if (start) begin
        age = 1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_char(int'(score), i));
      end
    end else if (age == 27) begin
      age = 0;
    end else begin
      age = age + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge Clk) begin
    logic       e_busy, e_done, e_we;
    logic [7:0] e_data;
    int         di;
    if (!Reset_n) begin
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en_a}, 32'd0);
      check("rst_wr_addr", {21'd0, wr_addr_a}, 32'd0);
      check("rst_wr_data", {24'd0, wr_data_a}, 32'd0);
    end else begin
      e_busy = (age >= 1 && age <= 26);
      e_we   = (age >= 21 && age <= 26);
      e_done = (age == 27);
      di     = age - 21;
      e_data = (e_we && exp_q.size() == 6) ? exp_q[di] : 8'h00;
      check("busy_a", {31'd0, busy_a}, {31'd0, e_busy});
      check("busy_b", {31'd0, busy_b}, {31'd0, e_busy});
      check("done_a", {31'd0, done_a}, {31'd0, e_done});
      check("done_b", {31'd0, done_b}, {31'd0, e_done});
      check("wr_en_a", {31'd0, wr_en_a}, {31'd0, e_we});
      check("wr_en_b", {31'd0, wr_en_b}, {31'd0, e_we});
      check("wr_data_a", {24'd0, wr_data_a}, {24'd0, e_data});
      check("wr_data_b", {24'd0, wr_data_b}, {24'd0, e_data});
      if (e_we) begin
        check("wr_addr_a", {21'd0, wr_addr_a}, {21'd0, 11'(int'(BASE_A) + di)});
        check("wr_addr_b", {21'd0, wr_addr_b}, {21'd0, 11'(int'(BASE_B) + di)});
      end
    end
  end

  // Write logs for the directed literal checks.
  logic [18:0] log_a[$];
  logic [18:0] log_b[$];
  always @(negedge Clk) begin
    if (wr_en_a) log_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) log_b.push_back({wr_addr_b, wr_data_b});
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic [19:0] s, output int lat);
    @(negedge Clk);
    start = 1'b1;
    score = s;
    @(negedge Clk);
    start = 1'b0;
    lat   = 1;
    while (!done_a && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    @(negedge Clk);
  endtask

  function automatic logic [19:0] rnd_score();
    case ($urandom_range(0, 5))
      0:       return 20'd0;
      1:       return 20'd999999;
      2:       return 20'd1000000;
      3:       return 20'hFFFFF;
      default: return 20'($urandom_range(0, 20'hFFFFF));
    endcase
  endfunction

  task automatic check_log_a(input string name, input logic [7:0] lit[6]);
    check({name, "_count"}, log_a.size(), 32'd6);
    for (int i = 0; i < 6 && i < log_a.size(); i++)
      check(name, {13'd0, log_a[i]}, {13'd0, 11'(int'(BASE_A) + i), lit[i]});
  endtask

  initial begin
    watchdog_guard();
  end

  task automatic watchdog_guard();
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  initial begin
    int          lat;
    logic [7:0]  lit[6];
    logic [10:0] addr_b[6];

    start   = 1'b0;
    score   = 20'd0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Model pins.
    check("model_909_2", {24'd0, exp_char(909, 2)},
`ifdef SCORE_LEADING_ZERO_BLANK_EN
          32'h20);
`else
          32'h30);
`endif
    check("model_909_4", {24'd0, exp_char(909, 4)}, 32'h30);
    check("model_sat", {24'd0, exp_char(1000000, 0)}, 32'h39);

    // 12345 at base 40.
    log_a.delete();
    op(20'd12345, lat);
    check("lat_12345", lat, 32'd27);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lit = '{8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
`else
    lit = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
`endif
    check_log_a("w12345", lit);

    // Zero.
    log_a.delete();
    op(20'd0, lat);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lit = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
`else
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
`endif
    check_log_a("w0", lit);

    // Saturation.
    log_a.delete();
    op(20'hFFFFF, lat);
    lit = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h39, 8'h39};
    check_log_a("wsat", lit);

    // Second start at CONVERT cycle 5 is dropped.
    log_a.delete();
    @(negedge Clk);
    start = 1'b1;
    score = 20'd4321;
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(negedge Clk);
    start = 1'b1;
    score = 20'd999;
    @(negedge Clk);
    start = 1'b0;
    lat = 0;
    while (!done_a && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    @(negedge Clk);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lit = '{8'h20, 8'h20, 8'h34, 8'h33, 8'h32, 8'h31};
`else
    lit = '{8'h30, 8'h30, 8'h34, 8'h33, 8'h32, 8'h31};
`endif
    check_log_a("wignore", lit);

    // Reset during the third write aborts asynchronously.
    log_a.delete();
    @(negedge Clk);
    start = 1'b1;
    score = 20'd555555;
    @(negedge Clk);
    start = 1'b0;
    lat = 0;
    while (!wr_en_a && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_wr_en", {31'd0, wr_en_a}, 32'd0);
    check("async_busy", {31'd0, busy_a}, 32'd0);
    check("async_done", {31'd0, done_a}, 32'd0);
    check("async_wr_data", {24'd0, wr_data_a}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (30) @(negedge Clk);
    check("abort_writes", log_a.size(), 32'd3);
    log_a.delete();
    op(20'd7, lat);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lit = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h37};
`else
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37};
`endif
    check_log_a("w7", lit);

    // Address wrap on the high-base instance.
    log_b.delete();
    op(20'd999999, lat);
    addr_b = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
    check("wrap_count", log_b.size(), 32'd6);
    for (int i = 0; i < 6 && i < log_b.size(); i++)
      check("wrap", {13'd0, log_b[i]}, {13'd0, addr_b[i], 8'h39});

    // Randomized traffic: held/overlapping starts, random scores, stray resets.
    repeat (150) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      start = 1'b1;
      for (int k = $urandom_range(1, 35); k > 0; k--) begin
        score = rnd_score();
        @(negedge Clk);
      end
      start = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        #2 Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
      end
    end
    repeat (40) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
